// File: rtl/reg_xfer_sched.sv
// -----------------------------------------------------------------------------
// reg_xfer_sched
//
// Transfer scheduler for the datapath register file. Arbitrates between two
// requesters (0 = instruction sequencer, 1 = debug/loader port) and sequences
// each granted transfer through READ -> (optional WRITE) -> DONE. It is the
// only driver of every register's bus0/bus1 read enable and load strobe.
//
// Ports
//   clk        system clock; scheduler acts on posedge, registers load on the
//              following negedge
//   reset_n    asynchronous active-low reset
//   reqN       level request from requester N, held until ackN
//   reqN_src0  register index driven onto bus0
//   reqN_src1  register index driven onto bus1
//   reqN_dst   destination index for write-back
//   reqN_wb    1 = perform the WRITE phase
//   ackN       one-cycle completion pulse to requester N
//   out0_en    one-hot/zero bus0 read enables
//   out1_en    one-hot/zero bus1 read enables
//   load       one-hot/zero load strobes
//   busy       high in every state except IDLE
//   owner      requester being served (valid while busy)
//   err        pulses with ack when a captured index was out of range
// -----------------------------------------------------------------------------
module reg_xfer_sched #(
  parameter int NUM_REGS     = 16,
  parameter int REG_IDX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    req0,
  input  logic [REG_IDX_BITS-1:0] req0_src0,
  input  logic [REG_IDX_BITS-1:0] req0_src1,
  input  logic [REG_IDX_BITS-1:0] req0_dst,
  input  logic                    req0_wb,
  output logic                    ack0,

  input  logic                    req1,
  input  logic [REG_IDX_BITS-1:0] req1_src0,
  input  logic [REG_IDX_BITS-1:0] req1_src1,
  input  logic [REG_IDX_BITS-1:0] req1_dst,
  input  logic                    req1_wb,
  output logic                    ack1,

  output logic [NUM_REGS-1:0]     out0_en,
  output logic [NUM_REGS-1:0]     out1_en,
  output logic [NUM_REGS-1:0]     load,
  output logic                    busy,
  output logic                    owner,
  output logic                    err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic                    r_last_grant;

  // Captured transfer fields (data only, no reset needed: they are always
  // written at the grant edge before anything consumes them).
  logic [REG_IDX_BITS-1:0] r_src0;
  logic [REG_IDX_BITS-1:0] r_src1;
  logic [REG_IDX_BITS-1:0] r_dst;
  logic                    r_wb;
  logic                    r_bad;

  logic                    w_any_req;
  logic                    w_sel;
  logic [REG_IDX_BITS-1:0] w_src0;
  logic [REG_IDX_BITS-1:0] w_src1;
  logic [REG_IDX_BITS-1:0] w_dst;
  logic                    w_wb;

  // Index -> one-hot enable; out-of-range indices decode to all-zero.
  function automatic logic [NUM_REGS-1:0] idx_decode(input logic [REG_IDX_BITS-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = (idx == REG_IDX_BITS'(i));
    end
    return v;
  endfunction

  function automatic logic idx_oor(input logic [REG_IDX_BITS-1:0] idx);
    return (int'(idx) >= NUM_REGS);
  endfunction

  // Lone requester wins outright; on a tie the one that did not win last.
  assign w_any_req = req0 | req1;
  assign w_sel     = (req0 & req1) ? ~r_last_grant : req1;
  assign w_src0    = w_sel ? req1_src0 : req0_src0;
  assign w_src1    = w_sel ? req1_src1 : req0_src1;
  assign w_dst     = w_sel ? req1_dst  : req0_dst;
  assign w_wb      = w_sel ? req1_wb   : req0_wb;

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_any_req) begin
      r_src0 <= w_src0;
      r_src1 <= w_src1;
      r_dst  <= w_dst;
      r_wb   <= w_wb;
      // dst only counts against the transfer when it is actually written.
      r_bad  <= idx_oor(w_src0) | idx_oor(w_src1) | (w_wb & idx_oor(w_dst));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      out0_en      <= '0;
      out1_en      <= '0;
      load         <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b0;
      err          <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      load <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_READ;
            r_last_grant <= w_sel;
            owner        <= w_sel;
            busy         <= 1'b1;
            out0_en      <= idx_decode(w_src0);
            out1_en      <= idx_decode(w_src1);
          end
        end
        S_READ: begin
          if (r_wb) begin
            // Enables stay up so the ALU result is stable while loading.
            r_state <= S_WRITE;
            load    <= idx_decode(r_dst);
          end else begin
            r_state <= S_DONE;
            out0_en <= '0;
            out1_en <= '0;
            ack0    <= ~owner;
            ack1    <= owner;
            err     <= r_bad;
          end
        end
        S_WRITE: begin
          r_state <= S_DONE;
          out0_en <= '0;
          out1_en <= '0;
          ack0    <= ~owner;
          ack1    <= owner;
          err     <= r_bad;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          out0_en <= '0;
          out1_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_xfer_sched.sv
module tb_reg_xfer_sched;

  logic clk;
  logic reset_n;

  // DUT A: 16 registers
  logic       a_req0, a_req0_wb, a_ack0;
  logic [3:0] a_req0_src0, a_req0_src1, a_req0_dst;
  logic       a_req1, a_req1_wb, a_ack1;
  logic [3:0] a_req1_src0, a_req1_src1, a_req1_dst;
  logic [15:0] a_out0, a_out1, a_load;
  logic       a_busy, a_owner, a_err;

  // DUT B: 12 registers, same 4-bit index
  logic       b_req0, b_req0_wb, b_ack0;
  logic [3:0] b_req0_src0, b_req0_src1, b_req0_dst;
  logic       b_req1, b_req1_wb, b_ack1;
  logic [3:0] b_req1_src0, b_req1_src1, b_req1_dst;
  logic [11:0] b_out0, b_out1, b_load;
  logic       b_busy, b_owner, b_err;

  int n_vec = 0;
  int n_err = 0;

  reg_xfer_sched #(.NUM_REGS(16), .REG_IDX_BITS(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0(a_req0), .req0_src0(a_req0_src0), .req0_src1(a_req0_src1),
    .req0_dst(a_req0_dst), .req0_wb(a_req0_wb), .ack0(a_ack0),
    .req1(a_req1), .req1_src0(a_req1_src0), .req1_src1(a_req1_src1),
    .req1_dst(a_req1_dst), .req1_wb(a_req1_wb), .ack1(a_ack1),
    .out0_en(a_out0), .out1_en(a_out1), .load(a_load),
    .busy(a_busy), .owner(a_owner), .err(a_err)
  );

  reg_xfer_sched #(.NUM_REGS(12), .REG_IDX_BITS(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0(b_req0), .req0_src0(b_req0_src0), .req0_src1(b_req0_src1),
    .req0_dst(b_req0_dst), .req0_wb(b_req0_wb), .ack0(b_ack0),
    .req1(b_req1), .req1_src0(b_req1_src0), .req1_src1(b_req1_src1),
    .req1_dst(b_req1_dst), .req1_wb(b_req1_wb), .ack1(b_ack1),
    .out0_en(b_out0), .out1_en(b_out1), .load(b_load),
    .busy(b_busy), .owner(b_owner), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants, checked every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("inv_a_out0_onehot", 32'($onehot0(a_out0)), 32'd1);
      chk("inv_a_out1_onehot", 32'($onehot0(a_out1)), 32'd1);
      chk("inv_a_load_onehot", 32'($onehot0(a_load)), 32'd1);
      chk("inv_a_single_ack",  32'(a_ack0 & a_ack1),  32'd0);
    end
  end

  initial begin
    reset_n = 1'b0;
    a_req0 = 0; a_req0_src0 = 0; a_req0_src1 = 0; a_req0_dst = 0; a_req0_wb = 0;
    a_req1 = 0; a_req1_src0 = 0; a_req1_src1 = 0; a_req1_dst = 0; a_req1_wb = 0;
    b_req0 = 0; b_req0_src0 = 0; b_req0_src1 = 0; b_req0_dst = 0; b_req0_wb = 0;
    b_req1 = 0; b_req1_src0 = 0; b_req1_src1 = 0; b_req1_dst = 0; b_req1_wb = 0;

    // ---- reset state ----
    #1;
    chk("rst_out0", 32'(a_out0), 32'h0);
    chk("rst_out1", 32'(a_out1), 32'h0);
    chk("rst_load", 32'(a_load), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_acks", 32'({a_ack0, a_ack1, a_err}), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // ---- req0: src0=2 src1=5 dst=7 wb=1 ----
    a_req0_src0 = 4'd2; a_req0_src1 = 4'd5; a_req0_dst = 4'd7; a_req0_wb = 1'b1;
    a_req0 = 1'b1;
    tick();
    chk("t1_read_out0", 32'(a_out0), 32'h0004);
    chk("t1_read_out1", 32'(a_out1), 32'h0020);
    chk("t1_read_load", 32'(a_load), 32'h0000);
    chk("t1_read_busy", 32'(a_busy), 32'h1);
    chk("t1_read_owner", 32'(a_owner), 32'h0);
    tick();
    chk("t1_write_out0", 32'(a_out0), 32'h0004);
    chk("t1_write_out1", 32'(a_out1), 32'h0020);
    chk("t1_write_load", 32'(a_load), 32'h0080);
    chk("t1_write_ack0", 32'(a_ack0), 32'h0);
    tick();
    chk("t1_done_ack0", 32'(a_ack0), 32'h1);
    chk("t1_done_ack1", 32'(a_ack1), 32'h0);
    chk("t1_done_load", 32'(a_load), 32'h0);
    chk("t1_done_out0", 32'(a_out0), 32'h0);
    chk("t1_done_err",  32'(a_err),  32'h0);
    chk("t1_done_busy", 32'(a_busy), 32'h1);
    a_req0 = 1'b0;
    tick();
    chk("t1_idle_busy", 32'(a_busy), 32'h0);
    chk("t1_idle_ack0", 32'(a_ack0), 32'h0);

    // ---- req1 only: src0=src1=3 wb=0 ----
    a_req1_src0 = 4'd3; a_req1_src1 = 4'd3; a_req1_dst = 4'd0; a_req1_wb = 1'b0;
    a_req1 = 1'b1;
    tick();
    chk("t2_read_out0", 32'(a_out0), 32'h0008);
    chk("t2_read_out1", 32'(a_out1), 32'h0008);
    chk("t2_read_owner", 32'(a_owner), 32'h1);
    tick();
    chk("t2_done_ack1", 32'(a_ack1), 32'h1);
    chk("t2_done_ack0", 32'(a_ack0), 32'h0);
    chk("t2_done_load", 32'(a_load), 32'h0);
    chk("t2_done_out0", 32'(a_out0), 32'h0);
    a_req1 = 1'b0;
    tick();
    chk("t2_idle_busy", 32'(a_busy), 32'h0);

    // ---- simultaneous requests, three rounds: grants 0,1,0 ----
    a_req0_src0 = 4'd1; a_req0_src1 = 4'd1; a_req0_wb = 1'b0;
    a_req1_src0 = 4'd4; a_req1_src1 = 4'd4; a_req1_wb = 1'b0;
    for (int r = 0; r < 3; r++) begin
      logic exp_own;
      exp_own = (r == 1);
      a_req0 = 1'b1; a_req1 = 1'b1;
      tick();
      chk("t3_owner", 32'(a_owner), 32'(exp_own));
      chk("t3_out0", 32'(a_out0), exp_own ? 32'h0010 : 32'h0002);
      tick();
      chk("t3_ack0", 32'(a_ack0), 32'(!exp_own));
      chk("t3_ack1", 32'(a_ack1), 32'(exp_own));
      chk("t3_ack_owner", 32'(a_owner), 32'(exp_own));
      if (exp_own) a_req1 = 1'b0; else a_req0 = 1'b0;
      tick();
      chk("t3_idle_busy", 32'(a_busy), 32'h0);
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
    tick();

    // ---- dst changed after capture ----
    a_req0_src0 = 4'd0; a_req0_src1 = 4'd1; a_req0_dst = 4'd4; a_req0_wb = 1'b1;
    a_req0 = 1'b1;
    tick();
    a_req0_dst = 4'd6;
    tick();
    chk("t6_load_captured", 32'(a_load), 32'h0010);
    tick();
    chk("t6_ack0", 32'(a_ack0), 32'h1);
    a_req0 = 1'b0;
    tick();

    // ---- reset during WRITE, then re-grant ----
    a_req0_src0 = 4'd2; a_req0_src1 = 4'd3; a_req0_dst = 4'd9; a_req0_wb = 1'b1;
    a_req0 = 1'b1;
    tick();
    tick();
    chk("t4_write_load", 32'(a_load), 32'h0200);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_rst_load", 32'(a_load), 32'h0);
    chk("t4_rst_out0", 32'(a_out0), 32'h0);
    chk("t4_rst_busy", 32'(a_busy), 32'h0);
    tick();
    chk("t4_rst_ack0", 32'(a_ack0), 32'h0);
    chk("t4_rst_load2", 32'(a_load), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("t4_regrant_busy", 32'(a_busy), 32'h1);
    chk("t4_regrant_owner", 32'(a_owner), 32'h0);
    chk("t4_regrant_out0", 32'(a_out0), 32'h0004);
    chk("t4_regrant_out1", 32'(a_out1), 32'h0008);
    tick();
    chk("t4_regrant_load", 32'(a_load), 32'h0200);
    tick();
    chk("t4_regrant_ack0", 32'(a_ack0), 32'h1);
    a_req0 = 1'b0;
    tick();

    // ---- NUM_REGS=12, src1=14 out of range ----
    b_req1_src0 = 4'd1; b_req1_src1 = 4'd14; b_req1_dst = 4'd0; b_req1_wb = 1'b0;
    b_req1 = 1'b1;
    tick();
    chk("t5_read_out0", 32'(b_out0), 32'h002);
    chk("t5_read_out1", 32'(b_out1), 32'h000);
    chk("t5_read_err",  32'(b_err),  32'h0);
    tick();
    chk("t5_done_ack1", 32'(b_ack1), 32'h1);
    chk("t5_done_err",  32'(b_err),  32'h1);
    chk("t5_done_load", 32'(b_load), 32'h0);
    b_req1 = 1'b0;
    tick();
    chk("t5_idle_err",  32'(b_err),  32'h0);
    chk("t5_idle_busy", 32'(b_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
